vending_fsm: RTL and testbench



---
 rtl/vending_fsm.sv | 145 ++++++++++++++
 tb/tb_vending_fsm.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_fsm.sv
// Four-drink vending controller.
// Collects coin credit in ACCEPT; on an armed drink selection either vends
// (shows change for one cycle in CHANGE) or refunds with an error pulse.
// total_money and error are registered; credit is visible at all times.
module vending_fsm #(
  parameter int unsigned PRICE_TEA    = 10,
  parameter int unsigned PRICE_COLA   = 15,
  parameter int unsigned PRICE_COFFEE = 20,
  parameter int unsigned PRICE_MILK   = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] coin,
  input  logic [2:0] drink_choose,
  output logic [7:0] total_money,
  output logic       error
);

  typedef enum logic [0:0] {StAccept, StChange} state_e;

  state_e     r_state, w_state_d;
  logic [7:0] r_credit, w_credit_d;
  logic [7:0] r_total, w_total_d;
  logic       r_error, w_error_d;
  logic       r_armed, w_armed_d;

  logic       w_coin_present;
  logic       w_coin_valid;
  logic [8:0] w_sum;
  logic       w_sum_ovf;
  logic       w_sel_drink;
  logic       w_sel_cancel;
  logic       w_sel_idle;
  logic [7:0] w_price;
  logic       w_afford;

  // A coin always takes priority over a selection in the same cycle.
  assign w_coin_present = (coin != 8'd0);
  assign w_coin_valid   = (coin == 8'd1) || (coin == 8'd5) || (coin == 8'd10) ||
                          (coin == 8'd50);
  assign w_sum          = {1'b0, r_credit} + {1'b0, coin};
  assign w_sum_ovf      = w_sum[8];

  // A selection is only acted upon once; returning to 0 re-arms it.
  assign w_sel_idle   = (drink_choose == 3'd0);
  assign w_sel_drink  = r_armed && (drink_choose >= 3'd1) && (drink_choose <= 3'd4);
  assign w_sel_cancel = r_armed && (drink_choose >= 3'd5);

  // Price lookup for the selected drink code.
  always_comb begin
    w_price = 8'd0;
    case (drink_choose)
      3'd1:    w_price = 8'(PRICE_TEA);
      3'd2:    w_price = 8'(PRICE_COLA);
      3'd3:    w_price = 8'(PRICE_COFFEE);
      3'd4:    w_price = 8'(PRICE_MILK);
      default: w_price = 8'd0;
    endcase
  end

  assign w_afford = (r_credit >= w_price);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StAccept;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic: a successful vend spends exactly one cycle in CHANGE.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StAccept: begin
        if (!w_coin_present && w_sel_drink && w_afford) begin
          w_state_d = StChange;
        end
      end
      StChange: w_state_d = StAccept;
    endcase
  end

  // Next values for credit, displayed amount, error pulse and selection arm.
  always_comb begin
    w_credit_d = r_credit;
    w_total_d  = r_credit;
    w_error_d  = 1'b0;
    w_armed_d  = r_armed;
    unique case (r_state)
      StAccept: begin
        if (w_coin_present) begin
          // Selection in the same cycle stays armed for the next cycle.
          if (w_coin_valid && !w_sum_ovf) begin
            w_credit_d = w_sum[7:0];
            w_total_d  = w_sum[7:0];
          end else begin
            w_error_d  = 1'b1;
          end
        end else if (w_sel_drink) begin
          w_armed_d  = 1'b0;
          w_credit_d = 8'd0;
          if (w_afford) begin
            w_total_d = r_credit - w_price;
          end else begin
            w_total_d = 8'd0;
            w_error_d = 1'b1;
          end
        end else if (w_sel_cancel) begin
          w_armed_d  = 1'b0;
          w_credit_d = 8'd0;
          w_total_d  = 8'd0;
        end
      end
      StChange: begin
        // Change already paid out; coins and selections here are dropped.
        w_credit_d = 8'd0;
        w_total_d  = 8'd0;
      end
    endcase
    if (w_sel_idle) begin
      w_armed_d = 1'b1;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credit <= 8'd0;
      r_total  <= 8'd0;
      r_error  <= 1'b0;
      r_armed  <= 1'b1;
    end else begin
      r_credit <= w_credit_d;
      r_total  <= w_total_d;
      r_error  <= w_error_d;
      r_armed  <= w_armed_d;
    end
  end

  assign total_money = r_total;
  assign error       = r_error;

endmodule

// File: tb/tb_vending_fsm.sv
// Self-checking bench for vending_fsm: directed scenarios with constant
// expectations, then random stimulus against a behavioural model.
module tb_vending_fsm;

  typedef struct packed {
    logic [7:0] c;
    logic [2:0] d;
    logic [7:0] t;
    logic       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] coin = 8'd0;
  logic [2:0] drink_choose = 3'd0;
  logic [7:0] total_money;
  logic       error;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state.
  int m_credit;
  int m_total;
  bit m_err;
  bit m_armed;
  bit m_change;
  int prices [5] = '{0, 10, 15, 20, 25};

  always #5 clk = ~clk;

  vending_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .coin         (coin),
    .drink_choose (drink_choose),
    .total_money  (total_money),
    .error        (error)
  );

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic [7:0] c, input logic [2:0] d);
    coin = c;
    drink_choose = d;
    @(posedge clk);
    #1;
  endtask

  // Model: one clock of the controller, computed from the vending rules.
  task automatic model_step(input logic [7:0] c, input logic [2:0] d);
    int sum;
    int price;
    m_err = 0;
    if (m_change) begin
      m_change = 0;
      m_total  = 0;
    end else if (c != 0) begin
      if (c == 1 || c == 5 || c == 10 || c == 50) begin
        sum = m_credit + int'(c);
        if (sum > 255) m_err = 1;
        else m_credit = sum;
      end else begin
        m_err = 1;
      end
      m_total = m_credit;
    end else if (m_armed && d >= 1 && d <= 4) begin
      price   = prices[d];
      m_armed = 0;
      if (m_credit >= price) begin
        m_total  = m_credit - price;
        m_change = 1;
      end else begin
        m_total = 0;
        m_err   = 1;
      end
      m_credit = 0;
    end else if (m_armed && d >= 5) begin
      m_armed  = 0;
      m_credit = 0;
      m_total  = 0;
    end else begin
      m_total = m_credit;
    end
    if (d == 0) m_armed = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    coin = 8'd0;
    drink_choose = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (total_money !== 8'd0) $display("FAIL reset_total got %0d expected 0", total_money);
    else n_pass++;
    n_checks++;
    if (error !== 1'b0) $display("FAIL reset_error got %0b expected 0", error);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_purchase();
    vec_t v [5] = '{
      '{8'd10, 3'd0, 8'd10, 1'b0}, '{8'd1, 3'd0, 8'd11, 1'b0},
      '{8'd10, 3'd0, 8'd21, 1'b0}, '{8'd0, 3'd3, 8'd1, 1'b0},
      '{8'd0, 3'd0, 8'd0, 1'b0}};
    foreach (v[i]) begin
      step(v[i].c, v[i].d);
      n_checks++;
      if (total_money !== v[i].t || error !== v[i].e)
        $display("FAIL purchase[%0d] total=%0d err=%0b expected total=%0d err=%0b",
                 i, total_money, error, v[i].t, v[i].e);
      else n_pass++;
    end
  endtask

  task automatic test_cancel_exact();
    vec_t v [13] = '{
      '{8'd5, 3'd0, 8'd5, 1'b0}, '{8'd10, 3'd0, 8'd15, 1'b0},
      '{8'd0, 3'd7, 8'd0, 1'b0}, '{8'd0, 3'd0, 8'd0, 1'b0},
      '{8'd10, 3'd0, 8'd10, 1'b0}, '{8'd10, 3'd0, 8'd20, 1'b0},
      '{8'd1, 3'd0, 8'd21, 1'b0}, '{8'd1, 3'd0, 8'd22, 1'b0},
      '{8'd1, 3'd0, 8'd23, 1'b0}, '{8'd1, 3'd0, 8'd24, 1'b0},
      '{8'd1, 3'd0, 8'd25, 1'b0}, '{8'd0, 3'd4, 8'd0, 1'b0},
      '{8'd0, 3'd0, 8'd0, 1'b0}};
    foreach (v[i]) begin
      step(v[i].c, v[i].d);
      n_checks++;
      if (total_money !== v[i].t || error !== v[i].e)
        $display("FAIL cancel_exact[%0d] total=%0d err=%0b expected total=%0d err=%0b",
                 i, total_money, error, v[i].t, v[i].e);
      else n_pass++;
    end
  endtask

  task automatic test_change_short();
    vec_t v [14] = '{
      '{8'd10, 3'd0, 8'd10, 1'b0}, '{8'd10, 3'd0, 8'd20, 1'b0},
      '{8'd0, 3'd2, 8'd5, 1'b0}, '{8'd0, 3'd0, 8'd0, 1'b0},
      '{8'd10, 3'd0, 8'd10, 1'b0}, '{8'd10, 3'd0, 8'd20, 1'b0},
      '{8'd0, 3'd4, 8'd0, 1'b1}, '{8'd0, 3'd0, 8'd0, 1'b0},
      '{8'd10, 3'd0, 8'd10, 1'b0}, '{8'd0, 3'd1, 8'd0, 1'b0},
      '{8'd0, 3'd0, 8'd0, 1'b0}, '{8'd50, 3'd0, 8'd50, 1'b0},
      '{8'd0, 3'd3, 8'd30, 1'b0}, '{8'd0, 3'd0, 8'd0, 1'b0}};
    foreach (v[i]) begin
      step(v[i].c, v[i].d);
      n_checks++;
      if (total_money !== v[i].t || error !== v[i].e)
        $display("FAIL change_short[%0d] total=%0d err=%0b expected total=%0d err=%0b",
                 i, total_money, error, v[i].t, v[i].e);
      else n_pass++;
    end
  endtask

  task automatic test_bad_coins();
    vec_t v [11] = '{
      '{8'd3, 3'd0, 8'd0, 1'b1}, '{8'd0, 3'd0, 8'd0, 1'b0},
      '{8'd50, 3'd0, 8'd50, 1'b0}, '{8'd50, 3'd0, 8'd100, 1'b0},
      '{8'd50, 3'd0, 8'd150, 1'b0}, '{8'd50, 3'd0, 8'd200, 1'b0},
      '{8'd50, 3'd0, 8'd250, 1'b0}, '{8'd10, 3'd0, 8'd250, 1'b1},
      '{8'd0, 3'd0, 8'd250, 1'b0}, '{8'd0, 3'd5, 8'd0, 1'b0},
      '{8'd0, 3'd0, 8'd0, 1'b0}};
    foreach (v[i]) begin
      step(v[i].c, v[i].d);
      n_checks++;
      if (total_money !== v[i].t || error !== v[i].e)
        $display("FAIL bad_coins[%0d] total=%0d err=%0b expected total=%0d err=%0b",
                 i, total_money, error, v[i].t, v[i].e);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    // Held selection vends once; coin+selection defers the selection;
    // coins during CHANGE are dropped.
    vec_t v [14] = '{
      '{8'd10, 3'd0, 8'd10, 1'b0}, '{8'd10, 3'd0, 8'd20, 1'b0},
      '{8'd0, 3'd1, 8'd10, 1'b0}, '{8'd0, 3'd1, 8'd0, 1'b0},
      '{8'd0, 3'd1, 8'd0, 1'b0}, '{8'd0, 3'd0, 8'd0, 1'b0},
      '{8'd10, 3'd0, 8'd10, 1'b0}, '{8'd10, 3'd2, 8'd20, 1'b0},
      '{8'd0, 3'd2, 8'd5, 1'b0}, '{8'd0, 3'd0, 8'd0, 1'b0},
      '{8'd10, 3'd0, 8'd10, 1'b0}, '{8'd0, 3'd1, 8'd0, 1'b0},
      '{8'd10, 3'd0, 8'd0, 1'b0}, '{8'd0, 3'd0, 8'd0, 1'b0}};
    foreach (v[i]) begin
      step(v[i].c, v[i].d);
      n_checks++;
      if (total_money !== v[i].t || error !== v[i].e)
        $display("FAIL back_to_back[%0d] total=%0d err=%0b expected total=%0d err=%0b",
                 i, total_money, error, v[i].t, v[i].e);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    step(8'd10, 3'd0);
    step(8'd5, 3'd0);
    step(8'd0, 3'd0);
    n_checks++;
    if (total_money !== 8'd15) $display("FAIL pre_reset_total got %0d expected 15", total_money);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (total_money !== 8'd0) $display("FAIL async_reset_total got %0d expected 0", total_money);
    else n_pass++;
    #2;
    reset = 1'b1;
    // Credit must not reappear after reset is released.
    step(8'd1, 3'd0);
    n_checks++;
    if (total_money !== 8'd1) $display("FAIL post_reset_total got %0d expected 1", total_money);
    else n_pass++;
    step(8'd0, 3'd6);
    step(8'd0, 3'd0);
  endtask

  task automatic test_random();
    logic [7:0] c;
    logic [2:0] d;
    int         r;
    logic [7:0] bad [4] = '{8'd2, 8'd3, 8'd7, 8'd100};
    reset = 1'b0;
    #3;
    reset = 1'b1;
    m_credit = 0;
    m_total  = 0;
    m_err    = 0;
    m_armed  = 1;
    m_change = 0;
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        5:       c = 8'd1;
        6:       c = 8'd5;
        7:       c = 8'd10;
        8:       c = 8'd50;
        9:       c = bad[$urandom_range(0, 3)];
        default: c = 8'd0;
      endcase
      if ($urandom_range(0, 11) < 6) d = 3'd0;
      else d = 3'($urandom_range(1, 7));
      step(c, d);
      model_step(c, d);
      n_checks++;
      if (total_money !== 8'(m_total) || error !== m_err)
        $display("FAIL random[%0d] coin=%0d sel=%0d total=%0d err=%0b expected total=%0d err=%0b",
                 k, c, d, total_money, error, m_total, m_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_purchase();
    test_cancel_exact();
    test_change_short();
    test_bad_coins();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
